rv32i_alu_decode_stage: RTL and testbench

//  Decode stage that produces the ALU's alu_op/a/b operands from RV32I OP, OP-IMM, LUI and AUIPC instructions.

---
 rtl/rv32i_alu_decode_stage.sv | 201 ++++++++++++++++++++
 tb/tb_rv32i_alu_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_decode_stage.sv
// Purpose : decodes RV32I OP / OP-IMM / LUI / AUIPC into ALU op + operands; all else flagged illegal.
// Latency : exactly 1 cycle from input transfer to out_valid; bundles leave in input order.
// Backpr. : valid/ready; out bundle held stable while stalled. ALU_DEC_SKID_EN adds a skid entry
//           and a registered in_ready; without it in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   in_valid/in_ready           input handshake
//   in_inst, in_pc              instruction word and its PC (PC feeds AUIPC)
//   in_rs1, in_rs2, in_tag      register values and opaque sideband tag
//   out_valid/out_ready         output handshake
//   out_alu_op, out_a, out_b    ALU opcode (4'hF = illegal) and operands
//   out_rd, out_we, out_illegal destination, write enable, illegal flag
//   out_tag                     tag registered alongside the bundle
// Build option: define ALU_DEC_SKID_EN for the 2-entry skid-buffered variant.
module rv32i_alu_decode_stage #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [3:0]       alu_op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [4:0]       rd;
    logic             we;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode  = in_inst[6:0];
  assign f3      = in_inst[14:12];
  assign f7_zero = (in_inst[31:25] == 7'b0000000);
  assign f7_alt  = (in_inst[31:25] == 7'b0100000);
  assign imm_i   = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_u   = {in_inst[31:12], 12'b0};
  assign shamt   = {27'b0, in_inst[24:20]};

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_legal;
  bundle_t     dec_d;

  always_comb begin
    dec_op    = ALU_ILL;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = in_rs1;
        dec_b = in_rs2;
        case (f3)
          3'b000: begin dec_legal = f7_zero | f7_alt; dec_op = f7_alt ? ALU_SUB : ALU_ADD; end
          3'b001: begin dec_legal = f7_zero; dec_op = ALU_SLL; end
          3'b010: begin dec_legal = f7_zero; dec_op = ALU_SLT; end
          3'b100: begin dec_legal = f7_zero; dec_op = ALU_XOR; end
          3'b101: begin dec_legal = f7_zero | f7_alt; dec_op = f7_alt ? ALU_SRA : ALU_SRL; end
          3'b110: begin dec_legal = f7_zero; dec_op = ALU_OR;  end
          3'b111: begin dec_legal = f7_zero; dec_op = ALU_AND; end
          default: dec_legal = 1'b0; // SLTU: no unsigned compare in the ALU
        endcase
      end
      OPC_OPIMM: begin
        dec_a = in_rs1;
        dec_b = imm_i;
        case (f3)
          3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
          3'b010: begin dec_legal = 1'b1; dec_op = ALU_SLT; end
          3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
          3'b001: begin dec_b = shamt; dec_legal = f7_zero; dec_op = ALU_SLL; end
          3'b101: begin
            dec_b     = shamt;
            dec_legal = f7_zero | f7_alt;
            dec_op    = f7_alt ? ALU_SRA : ALU_SRL;
          end
          default: dec_legal = 1'b0; // SLTIU
        endcase
      end
      OPC_LUI:   begin dec_legal = 1'b1; dec_op = ALU_ADD; dec_a = '0;    dec_b = imm_u; end
      OPC_AUIPC: begin dec_legal = 1'b1; dec_op = ALU_ADD; dec_a = in_pc; dec_b = imm_u; end
      default:   dec_legal = 1'b0;
    endcase

    dec_d         = '0;
    dec_d.rd      = in_inst[11:7];
    dec_d.tag     = in_tag;
    dec_d.illegal = !dec_legal;
    dec_d.alu_op  = dec_legal ? dec_op : ALU_ILL;
    dec_d.a       = dec_legal ? dec_a : 32'b0;
    dec_d.b       = dec_legal ? dec_b : 32'b0;
    dec_d.we      = dec_legal && (in_inst[11:7] != 5'd0);
  end

  bundle_t out_q;
  logic    out_valid_q;
  logic    in_fire;

  assign in_fire = in_valid && in_ready;

`ifdef ALU_DEC_SKID_EN
  bundle_t skid_q;
  logic    skid_full_q;

  // in_ready comes straight from a flop; a full skid always implies a valid output.
  assign in_ready = !skid_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else if (skid_full_q) begin
      if (out_ready) begin
        out_q       <= skid_q;
        skid_full_q <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || out_ready) begin
        out_q       <= dec_d;
        out_valid_q <= 1'b1;
      end else begin
        skid_q      <= dec_d;
        skid_full_q <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      out_q       <= dec_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign out_alu_op  = out_q.alu_op;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_rd      = out_q.rd;
  assign out_we      = out_q.we;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_rv32i_alu_decode_stage.sv
module tb_rv32i_alu_decode_stage;

  localparam int TAG_W = 8;
`ifdef ALU_DEC_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_op;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic [4:0]       out_rd;
  logic             out_we;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  rv32i_alu_decode_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_we(out_we), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [4:0]       rd;
    logic             we;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wire [82:0] obs_w = {out_alu_op, out_a, out_b, out_rd, out_we, out_illegal, out_tag};

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic we, input logic ill,
                              input logic [TAG_W-1:0] tag);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.ill = ill; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t mk_ill(input logic [4:0] rd, input logic [TAG_W-1:0] tag);
    return mk(4'hF, 32'h0, 32'h0, rd, 1'b0, 1'b1, tag);
  endfunction

  // One clock: settle, score any output transfer, record any input transfer, advance to next negedge.
  task automatic cycle(input exp_t e, output bit took);
    exp_t x;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag=%0d op=%h, scoreboard empty", out_tag, out_alu_op);
      end else begin
        x = sb.pop_front();
        if (obs_w !== {x.op, x.a, x.b, x.rd, x.we, x.ill, x.tag}) begin
          errors++;
          $display("FAIL bundle: got op=%h a=%h b=%h rd=%0d we=%b ill=%b tag=%0d, want op=%h a=%h b=%h rd=%0d we=%b ill=%b tag=%0d",
                   out_alu_op, out_a, out_b, out_rd, out_we, out_illegal, out_tag,
                   x.op, x.a, x.b, x.rd, x.we, x.ill, x.tag);
        end
      end
    end
    took = (in_valid === 1'b1 && in_ready === 1'b1);
    if (took) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [TAG_W-1:0] tag, input exp_t e);
    bit took = 1'b0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
    for (int i = 0; i < 20 && !took; i++) cycle(e, took);
    if (!took) begin
      checks++; errors++;
      $display("FAIL send_timeout: tag=%0d not accepted, in_ready=%b", tag, in_ready);
    end
  endtask

  task automatic drain();
    bit took;
    exp_t dummy;
    dummy = mk_ill(5'd0, '0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(dummy, took);
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d bundles outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs_w !== 83'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b fields=%h, want valid=0 fields=0", out_valid, obs_w);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, 8'h11, mk(4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 8'h11));
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: out_valid=%b one cycle after transfer, want 1", out_valid);
    end
    drain();
  endtask

  task automatic test_srai();
    out_ready = 1'b1;
    send(32'h40335293, 32'h0, 32'h80000010, 32'hDEAD, 8'h22,
         mk(4'h7, 32'h80000010, 32'd3, 5'd5, 1'b1, 1'b0, 8'h22));
    drain();
  endtask

  task automatic test_sltu();
    out_ready = 1'b1;
    send(32'h0020B1B3, 32'h0, 32'd9, 32'd4, 8'h33, mk_ill(5'd3, 8'h33));
    drain();
  endtask

  task automatic test_lui_auipc();
    out_ready = 1'b1;
    send(32'h123450B7, 32'h100, 32'hFFFF, 32'hFFFF, 8'h44,
         mk(4'h0, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0, 8'h44));
    send(32'h12345097, 32'h100, 32'hFFFF, 32'hFFFF, 8'h45,
         mk(4'h0, 32'h100, 32'h12345000, 5'd1, 1'b1, 1'b0, 8'h45));
    drain();
  endtask

  // Back-to-back mix of legal, illegal and x0-destination encodings under continuous ready.
  task automatic test_back_to_back();
    logic [31:0] insts[18];
    exp_t        exps[18];
    logic [31:0] ra, rb;
    ra = 32'hA5A50001; rb = 32'h00000013;
    insts[0]  = 32'h402081B3; exps[0]  = mk(4'h1, ra, rb, 5'd3, 1'b1, 1'b0, 8'd0);
    insts[1]  = 32'h002091B3; exps[1]  = mk(4'h5, ra, rb, 5'd3, 1'b1, 1'b0, 8'd1);
    insts[2]  = 32'h0020A1B3; exps[2]  = mk(4'h8, ra, rb, 5'd3, 1'b1, 1'b0, 8'd2);
    insts[3]  = 32'h0020C1B3; exps[3]  = mk(4'h4, ra, rb, 5'd3, 1'b1, 1'b0, 8'd3);
    insts[4]  = 32'h0020D1B3; exps[4]  = mk(4'h6, ra, rb, 5'd3, 1'b1, 1'b0, 8'd4);
    insts[5]  = 32'h4020D1B3; exps[5]  = mk(4'h7, ra, rb, 5'd3, 1'b1, 1'b0, 8'd5);
    insts[6]  = 32'h0020E1B3; exps[6]  = mk(4'h3, ra, rb, 5'd3, 1'b1, 1'b0, 8'd6);
    insts[7]  = 32'h0020F1B3; exps[7]  = mk(4'h2, ra, rb, 5'd3, 1'b1, 1'b0, 8'd7);
    insts[8]  = 32'h022081B3; exps[8]  = mk_ill(5'd3, 8'd8);
    insts[9]  = 32'h4020C1B3; exps[9]  = mk_ill(5'd3, 8'd9);
    insts[10] = 32'hFFF08193; exps[10] = mk(4'h0, ra, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0, 8'd10);
    insts[11] = 32'h0050B193; exps[11] = mk_ill(5'd3, 8'd11);
    insts[12] = 32'h01F09193; exps[12] = mk(4'h5, ra, 32'd31, 5'd3, 1'b1, 1'b0, 8'd12);
    insts[13] = 32'h41F09193; exps[13] = mk_ill(5'd3, 8'd13);
    insts[14] = 32'h8000C193; exps[14] = mk(4'h4, ra, 32'hFFFFF800, 5'd3, 1'b1, 1'b0, 8'd14);
    insts[15] = 32'h0040D193; exps[15] = mk(4'h6, ra, 32'd4, 5'd3, 1'b1, 1'b0, 8'd15);
    insts[16] = 32'h00508013; exps[16] = mk(4'h0, ra, 32'd5, 5'd0, 1'b0, 1'b0, 8'd16);
    insts[17] = 32'h0000A083; exps[17] = mk_ill(5'd1, 8'd17);
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) send(insts[i], 32'h1000, ra, rb, TAG_W'(i), exps[i]);
    send(32'hFFE0A193, 32'h1000, ra, rb, 8'd18, mk(4'h8, ra, 32'hFFFFFFFE, 5'd3, 1'b1, 1'b0, 8'd18));
    send(32'h00208033, 32'h1000, ra, rb, 8'd19, mk(4'h0, ra, rb, 5'd0, 1'b0, 1'b0, 8'd19));
    drain();
  endtask

  task automatic test_backpressure();
    int         idx = 0;
    bit         took;
    bit         have_snap = 1'b0;
    bit         exp_rdy;
    logic [82:0] snap = '0;
    exp_t       e;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e = mk(4'h0, 32'd100 + 32'(idx), 32'd200, 5'd3, 1'b1, 1'b0, TAG_W'(idx + 1));
      if (idx < 3) begin
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = '0;
        in_rs1 = 32'd100 + 32'(idx); in_rs2 = 32'd200; in_tag = TAG_W'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = (sb.size() < CAP);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL stall_in_ready: cycle %0d got %b want %b (held=%0d)", c, in_ready, exp_rdy, sb.size());
      end
      if (have_snap) begin
        checks++;
        if (obs_w !== snap || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_stable: cycle %0d valid=%b fields=%h, want valid=1 fields=%h", c, out_valid, obs_w, snap);
        end
      end else if (out_valid === 1'b1) begin
        snap = obs_w;
        have_snap = 1'b1;
      end
      cycle(e, took);
      if (took) idx++;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      e = mk(4'h0, 32'd100 + 32'(idx), 32'd200, 5'd3, 1'b1, 1'b0, TAG_W'(idx + 1));
      in_valid = 1'b1; in_inst = 32'h002081B3;
      in_rs1 = 32'd100 + 32'(idx); in_rs2 = 32'd200; in_tag = TAG_W'(idx + 1);
      cycle(e, took);
      if (took) idx++;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL stall_accept: accepted %0d inputs, want 3", idx);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    e = mk(4'h0, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0, 8'h66);
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd2, 8'h66, e);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL held_before_reset: out_valid=%b want 1", out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs_w !== 83'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b fields=%h, want valid=0 fields=0", out_valid, obs_w);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(32'h402081B3, 32'h0, 32'd9, 32'd4, 8'h67, mk(4'h1, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0, 8'h67));
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_srai();
    test_sltu();
    test_lui_auipc();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
